// File: rtl/hart_sched_pkg.sv
// hart_sched_pkg: shared types and constants for the hart scheduler.
//  - hart_state_e : per-hart IDLE/ACTIVE/PEND state
//  - hart_next_state() : single-hart next-state rule with event priority
//    kill > refill > miss > start.
package hart_sched_pkg;

  localparam int HART_NUM     = 4;
  localparam int HART_ID_W    = 2;
  localparam int HART_STATE_W = 2;
  localparam int CNT_W        = 32;

  typedef enum logic [HART_STATE_W-1:0] {
    HART_STATE_IDLE   = 2'b00,
    HART_STATE_ACTIVE = 2'b01,
    HART_STATE_PEND   = 2'b10
  } hart_state_e;

  // Each event only applies when the hart is in the state it acts on, so an
  // ignored higher-priority event lets a lower one through.
  function automatic hart_state_e hart_next_state(input hart_state_e cur,
                                                  input logic kill,
                                                  input logic refill,
                                                  input logic miss,
                                                  input logic start);
    hart_state_e nx;
    nx = cur;
    if (kill && (cur != HART_STATE_IDLE)) begin
      nx = HART_STATE_IDLE;
    end else if (refill && (cur == HART_STATE_PEND)) begin
      nx = HART_STATE_ACTIVE;
    end else if (miss && (cur == HART_STATE_ACTIVE)) begin
      nx = HART_STATE_PEND;
    end else if (start && (cur == HART_STATE_IDLE)) begin
      nx = HART_STATE_ACTIVE;
    end else begin
      nx = cur;
    end
    return nx;
  endfunction

endpackage

// File: rtl/hart_sched_if.sv
// hart_sched_if: bundle between the ID/I-cache side (master) and the hart
// scheduler (slave).
//  master drives: stall, hstart/hs_id, hkill/hk_id, cache_miss/cm_hart_id,
//                 refill_done/rf_hart_id
//  slave drives : hart_id, issue_en, hidle, hart_state, issue_cnt
interface hart_sched_if #(
  parameter int HART_NUM  = hart_sched_pkg::HART_NUM,
  parameter int HART_ID_W = hart_sched_pkg::HART_ID_W,
  parameter int CNT_W     = hart_sched_pkg::CNT_W
);
  logic                      stall;
  logic                      hstart;
  logic [HART_ID_W-1:0]      hs_id;
  logic                      hkill;
  logic [HART_ID_W-1:0]      hk_id;
  logic                      cache_miss;
  logic [HART_ID_W-1:0]      cm_hart_id;
  logic                      refill_done;
  logic [HART_ID_W-1:0]      rf_hart_id;
  logic [HART_ID_W-1:0]      hart_id;
  logic                      issue_en;
  logic                      hidle;
  logic [2*HART_NUM-1:0]     hart_state;
  logic [CNT_W*HART_NUM-1:0] issue_cnt;

  modport master (
    output stall, hstart, hs_id, hkill, hk_id, cache_miss, cm_hart_id,
           refill_done, rf_hart_id,
    input  hart_id, issue_en, hidle, hart_state, issue_cnt
  );

  modport slave (
    input  stall, hstart, hs_id, hkill, hk_id, cache_miss, cm_hart_id,
           refill_done, rf_hart_id,
    output hart_id, issue_en, hidle, hart_state, issue_cnt
  );
endinterface

// File: rtl/hart_sched_rr_pick.sv
// hart_sched_rr_pick: combinational rotate-priority picker.
//  active_mask : one bit per hart, 1 = eligible
//  last_id     : hart issued last; search starts at last_id+1 and ends at last_id
//  next_id     : first eligible hart in that order (last_id when none)
//  valid       : at least one hart is eligible
module hart_sched_rr_pick #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2
) (
  input  logic [HART_NUM-1:0]  active_mask,
  input  logic [HART_ID_W-1:0] last_id,
  output logic [HART_ID_W-1:0] next_id,
  output logic                 valid
);

  logic [HART_ID_W-1:0] cand_s;

  // Walk from the farthest candidate down to the nearest so the nearest hit
  // wins; HART_NUM is a power of two so id truncation gives the modulo wrap.
  always_comb begin
    next_id = last_id;
    valid   = 1'b0;
    cand_s  = last_id;
    for (int k = HART_NUM; k >= 1; k--) begin
      cand_s  = last_id + HART_ID_W'(k);
      next_id = active_mask[cand_s] ? cand_s : next_id;
      valid   = valid | active_mask[cand_s];
    end
  end

endmodule

// File: rtl/hart_sched.sv
// hart_sched: hart scheduler and state tracker for the barrel pipeline fetch side.
//  clk   : clock
//  reset : synchronous active-low reset (0 = reset)
//  bus   : hart_sched_if.slave -- start/kill requests, I-cache miss/refill
//          events and stall in; hart_id (registered), issue_en, hidle,
//          packed hart_state and issue_cnt out.
// Optional feature: define HART_ISSUE_CNT_EN to build per-hart issue counters;
// otherwise issue_cnt is tied to zero.
module hart_sched
  import hart_sched_pkg::*;
#(
  parameter int HART_NUM  = hart_sched_pkg::HART_NUM,
  parameter int HART_ID_W = hart_sched_pkg::HART_ID_W,
  parameter int CNT_W     = hart_sched_pkg::CNT_W
) (
  input logic        clk,
  input logic        reset,
  hart_sched_if.slave bus
);

  hart_state_e               state_r    [HART_NUM];
  hart_state_e               state_nx_s [HART_NUM];
  logic [HART_NUM-1:0]       kill_s;
  logic [HART_NUM-1:0]       active_nx_s;
  logic [HART_ID_W-1:0]      hart_id_r;
  logic [HART_ID_W-1:0]      pick_id_s;
  logic                      pick_valid_s;
  logic                      issue_en_s;
  logic [2*HART_NUM-1:0]     hart_state_s;
  logic [CNT_W*HART_NUM-1:0] issue_cnt_s;

  // Per-hart next state; start and kill are ignored during stall, miss/refill are not.
  always_comb begin
    for (int n = 0; n < HART_NUM; n++) begin
      kill_s[n] = bus.hkill & ~bus.stall & (bus.hk_id == HART_ID_W'(n)) &
                  (state_r[n] != HART_STATE_IDLE);
      state_nx_s[n] = hart_next_state(
        state_r[n],
        kill_s[n],
        bus.refill_done & (bus.rf_hart_id == HART_ID_W'(n)),
        bus.cache_miss  & (bus.cm_hart_id == HART_ID_W'(n)),
        bus.hstart & ~bus.stall & (bus.hs_id == HART_ID_W'(n)));
      active_nx_s[n] = (state_nx_s[n] == HART_STATE_ACTIVE);
    end
  end

  // Hart state register; after reset only hart 0 runs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < HART_NUM; n++) begin
        state_r[n] <= (n == 0) ? HART_STATE_ACTIVE : HART_STATE_IDLE;
      end
    end else begin
      for (int n = 0; n < HART_NUM; n++) begin
        state_r[n] <= state_nx_s[n];
      end
    end
  end

  // Selection looks at next-state so a miss drops its hart immediately.
  hart_sched_rr_pick #(
    .HART_NUM  (HART_NUM),
    .HART_ID_W (HART_ID_W)
  ) u_pick (
    .active_mask (active_nx_s),
    .last_id     (hart_id_r),
    .next_id     (pick_id_s),
    .valid       (pick_valid_s)
  );

  // Issue pointer; holds on stall or when no hart will be active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hart_id_r <= {HART_ID_W{1'b0}};
    end else if (!bus.stall && pick_valid_s) begin
      hart_id_r <= pick_id_s;
    end else begin
      hart_id_r <= hart_id_r;
    end
  end

  // Pack per-hart states into the flat output vector.
  always_comb begin
    hart_state_s = {(2*HART_NUM){1'b0}};
    for (int n = 0; n < HART_NUM; n++) begin
      hart_state_s[2*n +: 2] = state_r[n];
    end
  end

  assign issue_en_s     = (state_r[hart_id_r] == HART_STATE_ACTIVE);
  assign bus.hart_id    = hart_id_r;
  assign bus.issue_en   = issue_en_s;
  assign bus.hidle      = (state_r[bus.hs_id] == HART_STATE_IDLE);
  assign bus.hart_state = hart_state_s;

`ifdef HART_ISSUE_CNT_EN
  logic [CNT_W-1:0] cnt_r [HART_NUM];

  // Issue counters; a kill clears the counter even if that hart issues this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < HART_NUM; n++) begin
        cnt_r[n] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int n = 0; n < HART_NUM; n++) begin
        if (kill_s[n]) begin
          cnt_r[n] <= {CNT_W{1'b0}};
        end else if (!bus.stall && issue_en_s && (hart_id_r == HART_ID_W'(n))) begin
          cnt_r[n] <= cnt_r[n] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[n] <= cnt_r[n];
        end
      end
    end
  end

  // Pack counters into the flat output vector.
  always_comb begin
    issue_cnt_s = {(CNT_W*HART_NUM){1'b0}};
    for (int n = 0; n < HART_NUM; n++) begin
      issue_cnt_s[CNT_W*n +: CNT_W] = cnt_r[n];
    end
  end
`else
  assign issue_cnt_s = {(CNT_W*HART_NUM){1'b0}};
`endif

  assign bus.issue_cnt = issue_cnt_s;

endmodule

// File: tb/tb_hart_sched.sv
// tb_hart_sched: directed scenarios plus randomized traffic against a
// behavioural model of the hart scheduler.
module tb_hart_sched;

  localparam int HN = 4;
  localparam int IW = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hart_sched_if #(.HART_NUM(HN), .HART_ID_W(IW), .CNT_W(CW)) bus ();

  hart_sched #(.HART_NUM(HN), .HART_ID_W(IW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // model: 0 = idle, 1 = active, 2 = pending
  int          m_state [HN];
  int          m_hid;
  logic [CW-1:0] m_cnt [HN];

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < HN; n++) begin
      m_state[n] = (n == 0) ? 1 : 0;
      m_cnt[n]   = '0;
    end
    m_hid = 0;
  endtask

  task automatic compare();
    logic [2*HN-1:0]  exp_hs;
    logic [CW*HN-1:0] exp_cnt;
    exp_hs  = '0;
    exp_cnt = '0;
    for (int n = 0; n < HN; n++) begin
      exp_hs[2*n +: 2] = 2'(m_state[n]);
`ifdef HART_ISSUE_CNT_EN
      exp_cnt[CW*n +: CW] = m_cnt[n];
`endif
    end
    chk("hart_id",    128'(bus.hart_id),    128'(m_hid));
    chk("issue_en",   128'(bus.issue_en),   128'(m_state[m_hid] == 1));
    chk("hidle",      128'(bus.hidle),      128'(m_state[int'(bus.hs_id)] == 0));
    chk("hart_state", 128'(bus.hart_state), 128'(exp_hs));
    chk("issue_cnt",  128'(bus.issue_cnt),  128'(exp_cnt));
  endtask

  task automatic model_step();
    int   ns [HN];
    logic issue;
    logic found;
    int   c;
    if (!reset) begin
      model_reset();
    end else begin
      issue = !bus.stall && (m_state[m_hid] == 1);
      for (int n = 0; n < HN; n++) begin
        logic kill;
        kill = bus.hkill && !bus.stall && (int'(bus.hk_id) == n) && (m_state[n] != 0);
        ns[n] = m_state[n];
        if (kill)
          ns[n] = 0;
        else if (bus.refill_done && int'(bus.rf_hart_id) == n && m_state[n] == 2)
          ns[n] = 1;
        else if (bus.cache_miss && int'(bus.cm_hart_id) == n && m_state[n] == 1)
          ns[n] = 2;
        else if (bus.hstart && !bus.stall && int'(bus.hs_id) == n && m_state[n] == 0)
          ns[n] = 1;
        if (kill)
          m_cnt[n] = '0;
        else if (issue && m_hid == n)
          m_cnt[n] = m_cnt[n] + CW'(1);
      end
      if (!bus.stall) begin
        found = 1'b0;
        for (int k = 1; k <= HN; k++) begin
          c = (m_hid + k) % HN;
          if (!found && ns[c] == 1) begin
            m_hid = c;
            found = 1'b1;
          end
        end
      end
      for (int n = 0; n < HN; n++) m_state[n] = ns[n];
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic idle_in();
    bus.stall = 1'b0; bus.hstart = 1'b0; bus.hs_id = '0;
    bus.hkill = 1'b0; bus.hk_id = '0;
    bus.cache_miss = 1'b0; bus.cm_hart_id = '0;
    bus.refill_done = 1'b0; bus.rf_hart_id = '0;
  endtask

  initial begin
    idle_in();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // 1: reset for two cycles, then release
    cyc(); cyc();
    reset = 1'b1;
    settle();
    chk("rst_hart_state", 128'(bus.hart_state), 128'(8'h01));
    chk("rst_hart_id",    128'(bus.hart_id),    128'(2'd0));
    chk("rst_issue_en",   128'(bus.issue_en),   128'(1'b1));
    advance();
    settle();
    chk("single_hart_reissue", 128'(bus.hart_id), 128'(2'd0));
    advance();

    // 2: start harts 1 and 2
    bus.hstart = 1'b1; bus.hs_id = 2'd1;
    settle();
    chk("hidle_before_start", 128'(bus.hidle), 128'(1'b1));
    advance();
    bus.hs_id = 2'd2;
    cyc();
    bus.hstart = 1'b0; bus.hs_id = 2'd1;
    settle();
    chk("hidle_after_start", 128'(bus.hidle), 128'(1'b0));
    advance();
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("rr_seq", 128'(bus.hart_id), 128'(i % 3));
      advance();
    end

    // 3: miss on hart 1 while hart 0 issues, then refill
    bus.cache_miss = 1'b1; bus.cm_hart_id = 2'd1;
    settle();
    chk("miss_cycle_hid", 128'(bus.hart_id), 128'(2'd0));
    advance();
    bus.cache_miss = 1'b0;
    settle();
    chk("miss_skip_hid", 128'(bus.hart_id), 128'(2'd2));
    chk("miss_pend", 128'(bus.hart_state[3:2]), 128'(2'b10));
    advance();
    bus.refill_done = 1'b1; bus.rf_hart_id = 2'd1;
    cyc();
    bus.refill_done = 1'b0;
    settle();
    chk("refill_rejoin", 128'(bus.hart_id), 128'(2'd1));
    advance();

    // 4: stall with start on hart 3 and a miss on hart 0
    bus.stall = 1'b1; bus.hstart = 1'b1; bus.hs_id = 2'd3;
    cyc();
    bus.cache_miss = 1'b1; bus.cm_hart_id = 2'd0;
    cyc();
    bus.cache_miss = 1'b0;
    cyc();
    settle();
    chk("stall_hid_frozen", 128'(bus.hart_id), 128'(2'd2));
    chk("stall_no_start", 128'(bus.hart_state[7:6]), 128'(2'b00));
    chk("stall_miss_pend", 128'(bus.hart_state[1:0]), 128'(2'b10));
    bus.stall = 1'b0; bus.hstart = 1'b0;
    bus.refill_done = 1'b1; bus.rf_hart_id = 2'd0;
    advance();
    bus.refill_done = 1'b0;

    // 5: kill beats miss on hart 2; a later refill is ignored
    bus.hkill = 1'b1; bus.hk_id = 2'd2;
    bus.cache_miss = 1'b1; bus.cm_hart_id = 2'd2;
    cyc();
    bus.hkill = 1'b0; bus.cache_miss = 1'b0;
    settle();
    chk("kill_over_miss", 128'(bus.hart_state[5:4]), 128'(2'b00));
    advance();
    bus.refill_done = 1'b1; bus.rf_hart_id = 2'd2;
    cyc();
    bus.refill_done = 1'b0;
    settle();
    chk("refill_ignored", 128'(bus.hart_state[5:4]), 128'(2'b00));
    advance();

    // 6: issue counters
`ifdef HART_ISSUE_CNT_EN
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    bus.hstart = 1'b1; bus.hs_id = 2'd1;
    cyc();
    bus.hstart = 1'b0;
    repeat (9) cyc();
    settle();
    chk("cnt_hart0", 128'(bus.issue_cnt[CW-1:0]),    128'(32'd5));
    chk("cnt_hart1", 128'(bus.issue_cnt[2*CW-1:CW]), 128'(32'd5));
    bus.hkill = 1'b1; bus.hk_id = 2'd1;
    advance();
    bus.hkill = 1'b0;
    settle();
    chk("cnt_kill_clear", 128'(bus.issue_cnt[2*CW-1:CW]), 128'(32'd0));
    advance();
`else
    settle();
    chk("cnt_tied_zero", 128'(bus.issue_cnt), 128'(0));
    advance();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 199) != 0);
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.hstart      = ($urandom_range(0, 2) == 0);
      bus.hs_id       = IW'($urandom_range(0, HN-1));
      bus.hkill       = ($urandom_range(0, 5) == 0);
      bus.hk_id       = IW'($urandom_range(0, HN-1));
      bus.cache_miss  = ($urandom_range(0, 2) == 0);
      bus.cm_hart_id  = IW'($urandom_range(0, HN-1));
      bus.refill_done = ($urandom_range(0, 2) == 0);
      bus.rf_hart_id  = IW'($urandom_range(0, HN-1));
      cyc();
    end
    reset = 1'b1;
    idle_in();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
